// File: rtl/nf_bus_pkg.sv
// Shared types and constants for the nanoFOX two-master memory-bus arbiter.
package nf_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic {
    MST_IF  = 1'b0,
    MST_LSU = 1'b1
  } mst_t;

endpackage

// File: rtl/nf_bus_timeout.sv
// Slave wait-cycle counter: saturating, with synchronous clear and an expire
// flag raised on the last permitted wait cycle. TIMEOUT = 0 never expires.
module nf_bus_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

  assign expire = (TIMEOUT != 0) && en && (count == LIMIT);

endmodule

// File: rtl/nf_bus_arb.sv
// Two-master (fetch / load-store) to one-slave memory-bus arbiter with
// req/ack handshakes, fixed or round-robin priority and slave timeout.
module nf_bus_arb
  import nf_bus_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic              s_req,
  output logic              s_we,
  output logic [1:0]        s_size,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ack
);

  arb_state_t state;
  mst_t       last_grant;
  logic       i_elig, d_elig, grant_lsu, in_bus, expire;

  // A master whose ack is high this cycle is still holding req; don't regrant it.
  assign i_elig = i_req & ~i_ack;
  assign d_elig = d_req & ~d_ack;
  assign in_bus = (state == BUS_I) || (state == BUS_D);

  always_comb begin
    grant_lsu = d_elig;
    if (i_elig && d_elig) begin
      grant_lsu = (PRIO_MODE == 0) ? 1'b1 : (last_grant == MST_IF);
    end
  end

  nf_bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (~in_bus | s_ack),
    .en     (in_bus),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= MST_IF;
      s_req      <= 1'b0;
      s_we       <= 1'b0;
      s_size     <= '0;
      s_addr     <= '0;
      s_wdata    <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_err      <= 1'b0;
      d_err      <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      i_err <= 1'b0;
      d_err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_elig || d_elig) begin
            s_req <= 1'b1;
            if (grant_lsu) begin
              s_addr  <= d_addr;
              s_we    <= d_we;
              s_size  <= d_size;
              s_wdata <= d_wdata;
              state   <= BUS_D;
            end else begin
              s_addr  <= i_addr;
              s_we    <= 1'b0;
              s_size  <= SZ_W;
              s_wdata <= '0;
              state   <= BUS_I;
            end
          end
        end
        BUS_I, BUS_D: begin
          // s_ack takes precedence over an expiry in the same cycle.
          if (s_ack || expire) begin
            s_req <= 1'b0;
            state <= RESP;
            if (state == BUS_I) begin
              i_ack   <= 1'b1;
              i_err   <= ~s_ack;
              i_rdata <= s_ack ? s_rdata : '0;
            end else begin
              d_ack   <= 1'b1;
              d_err   <= ~s_ack;
              d_rdata <= s_ack ? s_rdata : '0;
            end
            if (s_ack) begin
              last_grant <= (state == BUS_I) ? MST_IF : MST_LSU;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nf_bus_arb.md
Name: nf_bus_arb

Overview:
- Two-master, one-slave memory-bus arbiter for the nanoFOX core.
- Shares a single memory port between the instruction-fetch path and the load/store path of nf_cpu.
- Sequences each access with a req/ack handshake, enforces fixed or round-robin priority, and converts a stuck slave access into an error response after a programmable timeout.
- Sits between nf_cpu and the memory/peripheral interconnect inside nf_top.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- PRIO_MODE, 0, 0 = fixed (LSU beats IF), 1 = round-robin on simultaneous requests.
- TIMEOUT, 255, slave wait-cycle limit before error; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetch read data, valid with i_ack
- i_ack  out  1  one-cycle fetch completion pulse
- i_err  out  1  fetch timed out, valid with i_ack
- d_req  in  1  load/store request, held until d_ack
- d_we  in  1  1 = store
- d_size  in  2  0 = byte, 1 = half, 2 = word
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid with d_ack
- d_ack  out  1  one-cycle data completion pulse
- d_err  out  1  data access timed out, valid with d_ack
- s_req  out  1  slave request, held until s_ack
- s_we  out  1  slave write enable
- s_size  out  2  slave access size
- s_addr  out  ADDR_W  slave address
- s_wdata  out  DATA_W  slave write data
- s_rdata  in  DATA_W  slave read data, sampled on s_ack
- s_ack  in  1  slave completion, one cycle per request

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - s_req, s_we, i_ack, d_ack, i_err, d_err = 0.
  - s_addr, s_wdata, s_size, i_rdata, d_rdata = 0.
  - Wait counter = 0; last_grant = IF.
  - An in-flight access is abandoned; no ack is issued.
- States:
  - IDLE: arbitrate.
  - BUS_I / BUS_D: s_req high, waiting for s_ack.
  - RESP: one-cycle acknowledge to the owner.
- IDLE:
  - Eligible requesters are those with req=1 and their own ack=0 in this cycle. Masking out the acked master prevents re-grant of a request that is still high in its ack cycle.
  - Single eligible requester: it is granted.
  - Both eligible, PRIO_MODE=0: LSU is granted.
  - Both eligible, PRIO_MODE=1: the master not equal to last_grant is granted.
  - On grant, latch the request fields into s_addr, s_we, s_size, s_wdata. For IF, s_we=0, s_size=2, s_wdata=0.
  - On grant, set s_req=1 and go to BUS_x. s_req is therefore high one cycle after the request is first seen.
- BUS_x:
  - s_req and the latched fields stay stable until exit.
  - On s_ack: capture s_rdata into the owner's rdata register (stores capture too). Go to RESP with err=0, s_req=0, counter=0, last_grant=owner.
  - No s_ack: increment the counter.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without s_ack: go to RESP with err=1, owner rdata=0, s_req=0.
  - s_ack arriving in the same cycle as the timeout: the ack wins, err=0.
- RESP:
  - Owner ack=1 for exactly one cycle; err valid only in this cycle.
  - Next state is IDLE.
  - Minimum transaction is 3 cycles: grant, s_ack in the first BUS cycle, RESP.
- rdata holds its value until the next completion to the same master.
- s_ack while in IDLE or RESP is ignored.
- Request fields are sampled only at grant; changes while the request is waiting are not observed.
- The counter is wide enough for TIMEOUT and saturates; it never wraps.

Decomposition:
- Package nf_bus_pkg:
  - enum arb_state_t {IDLE, BUS_I, BUS_D, RESP}.
  - Size constants SZ_B=0, SZ_H=1, SZ_W=2.
  - Master-id enum {MST_IF, MST_LSU}.
- One sub-module, nf_bus_timeout: counter with clear/enable/expire, parameterized by TIMEOUT.
- Arbitration and the FSM remain in nf_bus_arb.

Test Plan:
- Fetch only, slave acks 2 cycles after s_req:
  - i_req=1, i_addr=0x0000_0010, s_rdata=0x0050_0093.
  - Expect s_req high for 3 cycles, s_addr=0x10, s_we=0.
  - Expect i_ack one cycle after s_ack with i_rdata=0x0050_0093 and i_err=0.
- Store only:
  - d_req=1, d_we=1, d_size=0, d_addr=0x0001_0004, d_wdata=0xA5.
  - Expect s_we=1, s_size=0, s_wdata=0xA5, d_ack pulse, i_ack never asserted.
- Simultaneous requests, PRIO_MODE=0, 4 back-to-back pairs:
  - Expect LSU served first each time and IF served after each LSU.
  - Expect no master acked twice for one request.
- Simultaneous requests, PRIO_MODE=1, both held continuously for 6 transactions:
  - Expect grant order LSU, IF, LSU, IF, LSU, IF (last_grant=IF after reset).
- Timeout, TIMEOUT=8, slave never acks a fetch:
  - Expect s_req high for exactly 8 cycles, then i_ack=1, i_err=1, i_rdata=0.
  - Expect the next request to proceed normally.
- Reset mid-access:
  - Assert reset for 1 cycle while in BUS_D.
  - Expect s_req=0 asynchronously and no d_ack.
  - After release, a held d_req is re-granted from IDLE.
